// File: rtl/nina_prog_pkg.sv
// nina_prog_pkg -- shared types and helpers for the NINA-W102 programming controller.
//   state_t    : sequencer states (IDLE, RST, BOOT_HOLD); encodings match the oMODE codes
//   MODE_*     : oMODE output codes
//   cnt_width  : width of the sequence counter, wide enough for the longest phase
package nina_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RST       = 2'b01,
    ST_BOOT_HOLD = 2'b10
  } state_t;

  localparam logic [1:0] MODE_IDLE      = 2'b00;
  localparam logic [1:0] MODE_RST       = 2'b01;
  localparam logic [1:0] MODE_BOOT_HOLD = 2'b10;

  // Counter width = clog2(max(rst_cyc, hold_cyc, 2) + 1).
  function automatic int cnt_width(input int rst_cyc, input int hold_cyc);
    int m;
    m = (rst_cyc > hold_cyc) ? rst_cyc : hold_cyc;
    m = (m < 2) ? 2 : m;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nina_btn_debounce.sv
// nina_btn_debounce -- 2-flop synchroniser plus stability counter for one raw button.
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   btn_n  in  raw button, active-low, asynchronous
//   deb_n  out debounced level; changes only after the synchronised input has
//              differed from it for DEB_CYC consecutive cycles; resets to 1
module nina_btn_debounce #(
  parameter int DEB_CYC = 48000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic deb_n
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          deb_r;

  // Synchronise the button and count consecutive cycles it disagrees with the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
      cnt_r  <= {CW{1'b0}};
      deb_r  <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], btn_n};
      if (sync_r[1] == deb_r) begin
        // Any return to the current level restarts the stability window.
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        deb_r <= sync_r[1];
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign deb_n = deb_r;

endmodule

// File: rtl/nina_prog_ctrl.sv
// nina_prog_ctrl -- NINA-W102 (ESP32) programming/boot controller.
// Muxes N_HOST host UARTs onto the ESP32 UART and sequences ESP32 EN (oESP_RSTn)
// and IO0 (oESP_BOOTn) from debounced buttons, power-on and optional DTR/RTS auto-reset.
// Optional feature macro: NINA_PROG_AUTORESET_EN (esptool-style DTR/RTS auto-reset).
// Ports:
//   iCLK, iRESET            clock, synchronous active-high reset
//   iSEL                    host select, sampled only while idle
//   iHOST_TX / oHOST_RX     host UART lines (one per host)
//   iHOST_DTRn / iHOST_RTSn host modem lines, active-low (used only with the macro)
//   iRESET_BTNn/iBOOT_BTNn  raw buttons, active-low
//   iESP_TX / oESP_RX       ESP32 UART
//   oESP_RSTn / oESP_BOOTn  ESP32 EN / IO0
//   oBUSY, oMODE            sequence status (00 idle, 01 reset, 10 boot hold)
module nina_prog_ctrl
  import nina_prog_pkg::*;
#(
  parameter int N_HOST        = 2,
  parameter int DEB_CYC       = 48000,
  parameter int RST_CYC       = 4800000,
  parameter int BOOT_HOLD_CYC = 2400000,
  localparam int SW = (N_HOST > 1) ? $clog2(N_HOST) : 1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [SW-1:0]     iSEL,
  input  logic [N_HOST-1:0] iHOST_TX,
  output logic [N_HOST-1:0] oHOST_RX,
  input  logic [N_HOST-1:0] iHOST_DTRn,
  input  logic [N_HOST-1:0] iHOST_RTSn,
  input  logic              iRESET_BTNn,
  input  logic              iBOOT_BTNn,
  input  logic              iESP_TX,
  output logic              oESP_RX,
  output logic              oESP_RSTn,
  output logic              oESP_BOOTn,
  output logic              oBUSY,
  output logic [1:0]        oMODE
);

  localparam int CW = cnt_width(RST_CYC, BOOT_HOLD_CYC);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(BOOT_HOLD_CYC - 1);

  state_t            state_r, state_next;
  logic [CW-1:0]     cnt_r, cnt_next;
  logic              flag_r, flag_next;
  logic [SW-1:0]     sel_r, sel_in_s;
  logic [N_HOST-1:0] tx_s1_r, tx_s2_r;
  logic              esp_s1_r, esp_s2_r;
  logic              rst_deb_s, boot_deb_s, rst_prev_r;
  logic              btn_fall_s, boot_held_s, trig_s;
  logic              ar_trig_s, boot_cond_s;
  logic [N_HOST-1:0] host_rx_next;
  logic [1:0]        mode_next;

  logic              rstn_r, bootn_r, esp_rx_r, busy_r;
  logic [N_HOST-1:0] host_rx_r;
  logic [1:0]        mode_r;

  nina_btn_debounce #(.DEB_CYC(DEB_CYC)) u_rst_btn (
    .clk   (iCLK),
    .reset (iRESET),
    .btn_n (iRESET_BTNn),
    .deb_n (rst_deb_s)
  );

  nina_btn_debounce #(.DEB_CYC(DEB_CYC)) u_boot_btn (
    .clk   (iCLK),
    .reset (iRESET),
    .btn_n (iBOOT_BTNn),
    .deb_n (boot_deb_s)
  );

  // Out-of-range selects fall back to host 0.
  assign sel_in_s    = (int'(iSEL) < N_HOST) ? iSEL : {SW{1'b0}};
  assign btn_fall_s  = rst_prev_r & ~rst_deb_s;
  assign boot_held_s = ~boot_deb_s;
  assign trig_s      = btn_fall_s | ar_trig_s;

`ifdef NINA_PROG_AUTORESET_EN
  logic [N_HOST-1:0] dtrn_s1_r, dtrn_s2_r, rtsn_s1_r, rtsn_s2_r;
  logic              ar_cond_s, ar_prev_r;

  // esptool drives RTS with DTR released to pulse EN, and DTR with RTS released to pull IO0.
  assign ar_cond_s   = ~rtsn_s2_r[sel_r] &  dtrn_s2_r[sel_r];
  assign boot_cond_s = ~dtrn_s2_r[sel_r] &  rtsn_s2_r[sel_r];
  assign ar_trig_s   = ar_cond_s & ~ar_prev_r;

  // Synchronise host modem lines and remember the previous auto-reset condition.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      dtrn_s1_r <= {N_HOST{1'b1}};
      dtrn_s2_r <= {N_HOST{1'b1}};
      rtsn_s1_r <= {N_HOST{1'b1}};
      rtsn_s2_r <= {N_HOST{1'b1}};
      ar_prev_r <= 1'b0;
    end else begin
      dtrn_s1_r <= iHOST_DTRn;
      dtrn_s2_r <= dtrn_s1_r;
      rtsn_s1_r <= iHOST_RTSn;
      rtsn_s2_r <= rtsn_s1_r;
      ar_prev_r <= ar_cond_s;
    end
  end
`else
  logic unused_modem_s;

  assign unused_modem_s = ^{iHOST_DTRn, iHOST_RTSn};
  assign ar_trig_s      = 1'b0;
  assign boot_cond_s    = 1'b0;
`endif

  // Sequencer next-state, counter and boot flag.
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    flag_next  = flag_r;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_next = ST_RST;
          cnt_next   = {CW{1'b0}};
          flag_next  = boot_held_s;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RST: begin
        flag_next = flag_r | boot_held_s | boot_cond_s;
        if (cnt_r >= RST_LAST) begin
          cnt_next   = {CW{1'b0}};
          state_next = flag_next ? ST_BOOT_HOLD : ST_IDLE;
        end else begin
          cnt_next = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_BOOT_HOLD: begin
        if (cnt_r >= HOLD_LAST) begin
          cnt_next   = {CW{1'b0}};
          flag_next  = 1'b0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = {CW{1'b0}};
        flag_next  = 1'b0;
      end
    endcase
  end

  // Mode code and host RX fan-out for the next registered output values.
  always_comb begin
    case (state_next)
      ST_IDLE:      mode_next = MODE_IDLE;
      ST_RST:       mode_next = MODE_RST;
      ST_BOOT_HOLD: mode_next = MODE_BOOT_HOLD;
      default:      mode_next = MODE_IDLE;
    endcase
    host_rx_next = {N_HOST{1'b1}};
    for (int i = 0; i < N_HOST; i++) begin
      if (SW'(i) == sel_r) begin
        host_rx_next[i] = esp_s2_r;
      end else begin
        host_rx_next[i] = 1'b1;
      end
    end
  end

  // State, counter, host latch, UART synchronisers and registered outputs.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_r    <= ST_RST;
      cnt_r      <= {CW{1'b0}};
      flag_r     <= 1'b0;
      sel_r      <= {SW{1'b0}};
      rst_prev_r <= 1'b1;
      tx_s1_r    <= {N_HOST{1'b1}};
      tx_s2_r    <= {N_HOST{1'b1}};
      esp_s1_r   <= 1'b1;
      esp_s2_r   <= 1'b1;
      rstn_r     <= 1'b0;
      bootn_r    <= 1'b1;
      esp_rx_r   <= 1'b1;
      host_rx_r  <= {N_HOST{1'b1}};
      busy_r     <= 1'b1;
      mode_r     <= MODE_RST;
    end else begin
      state_r    <= state_next;
      cnt_r      <= cnt_next;
      flag_r     <= flag_next;
      sel_r      <= (state_r == ST_IDLE) ? sel_in_s : sel_r;
      rst_prev_r <= rst_deb_s;
      tx_s1_r    <= iHOST_TX;
      tx_s2_r    <= tx_s1_r;
      esp_s1_r   <= iESP_TX;
      esp_s2_r   <= esp_s1_r;
      // Outputs follow the next state so they line up with state_r.
      rstn_r     <= (state_next != ST_RST);
      bootn_r    <= (state_next != ST_BOOT_HOLD);
      esp_rx_r   <= (state_next == ST_RST) ? 1'b1 : tx_s2_r[sel_r];
      host_rx_r  <= host_rx_next;
      busy_r     <= (state_next != ST_IDLE);
      mode_r     <= mode_next;
    end
  end

  assign oESP_RSTn  = rstn_r;
  assign oESP_BOOTn = bootn_r;
  assign oESP_RX    = esp_rx_r;
  assign oHOST_RX   = host_rx_r;
  assign oBUSY      = busy_r;
  assign oMODE      = mode_r;

endmodule

// File: tb/tb_nina_prog_ctrl.sv
// tb_nina_prog_ctrl -- scoreboard bench for nina_prog_ctrl (N_HOST=2, DEB_CYC=4,
// RST_CYC=10, BOOT_HOLD_CYC=6). Expected sequences / UART samples are queued when
// stimulus is driven and checked when the DUT completes them.
module tb_nina_prog_ctrl;

  typedef struct {
    int rlen;
    int blen;
  } seq_t;

  typedef struct {
    int         due;
    bit         kind;
    logic [1:0] exp;
  } ux_t;

  logic       clk = 1'b0;
  logic       iRESET = 1'b1;
  logic [0:0] iSEL = 1'b0;
  logic [1:0] iHOST_TX = 2'b11;
  logic [1:0] iHOST_DTRn = 2'b11;
  logic [1:0] iHOST_RTSn = 2'b11;
  logic       iRESET_BTNn = 1'b1;
  logic       iBOOT_BTNn = 1'b1;
  logic       iESP_TX = 1'b1;
  logic [1:0] oHOST_RX;
  logic       oESP_RX, oESP_RSTn, oESP_BOOTn, oBUSY;
  logic [1:0] oMODE;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_unexp = 0;
  int   cyc     = 0;
  seq_t sb[$];
  ux_t  uq[$];

  nina_prog_ctrl #(.N_HOST(2), .DEB_CYC(4), .RST_CYC(10), .BOOT_HOLD_CYC(6)) dut (
    .iCLK(clk), .iRESET(iRESET), .iSEL(iSEL), .iHOST_TX(iHOST_TX), .oHOST_RX(oHOST_RX),
    .iHOST_DTRn(iHOST_DTRn), .iHOST_RTSn(iHOST_RTSn), .iRESET_BTNn(iRESET_BTNn),
    .iBOOT_BTNn(iBOOT_BTNn), .iESP_TX(iESP_TX), .oESP_RX(oESP_RX), .oESP_RSTn(oESP_RSTn),
    .oESP_BOOTn(oESP_BOOTn), .oBUSY(oBUSY), .oMODE(oMODE)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sequence and UART monitor, sampling on the falling edge.
  initial begin : mon
    int busy_n, r_low, b_low, m01, m10, ovl, rxbad;
    bit in_seq;
    seq_t it;
    ux_t u;
    busy_n = 0; r_low = 0; b_low = 0; m01 = 0; m10 = 0; ovl = 0; rxbad = 0; in_seq = 1'b0;
    forever begin
      @(negedge clk);
      if (iRESET) begin
        in_seq = 1'b1;
        busy_n = 0; r_low = 0; b_low = 0; m01 = 0; m10 = 0; ovl = 0; rxbad = 0;
      end else if (oBUSY === 1'b1) begin
        in_seq = 1'b1;
        busy_n++;
        if (oESP_RSTn === 1'b0) r_low++;
        if (oESP_BOOTn === 1'b0) b_low++;
        if (oMODE === 2'b01) m01++;
        if (oMODE === 2'b10) m10++;
        if (oESP_RSTn === 1'b0 && oESP_BOOTn === 1'b0) ovl++;
        if (oESP_RSTn === 1'b0 && oESP_RX !== 1'b1) rxbad++;
      end else if (in_seq) begin
        if (sb.size() == 0) begin
          n_unexp++;
        end else begin
          it = sb.pop_front();
          check_val("rstn_low_len", r_low, it.rlen);
          check_val("mode01_len", m01, it.rlen);
          check_val("bootn_low_len", b_low, it.blen);
          check_val("mode10_len", m10, it.blen);
          check_val("busy_len", busy_n, it.rlen + it.blen);
          check_val("rst_boot_overlap", ovl, 0);
          check_val("esp_rx_forced", rxbad, 0);
        end
        in_seq = 1'b0;
        busy_n = 0; r_low = 0; b_low = 0; m01 = 0; m10 = 0; ovl = 0; rxbad = 0;
      end
      while (uq.size() > 0 && uq[0].due <= cyc) begin
        u = uq.pop_front();
        if (u.kind == 1'b0) check_val("esp_rx_pass", oESP_RX, u.exp[0]);
        else                check_val("host_rx_pass", oHOST_RX, u.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_seq(input string tag);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    check_val(tag, sb.size(), 0);
  endtask

  task automatic wait_mode(input logic [1:0] m, input string tag);
    for (int i = 0; i < 40 && oMODE !== m; i++) @(negedge clk);
    check_val(tag, oMODE, m);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check_val({tag, "_busy"}, oBUSY, 1'b0);
    check_val({tag, "_rstn"}, oESP_RSTn, 1'b1);
    check_val({tag, "_bootn"}, oESP_BOOTn, 1'b1);
    check_val({tag, "_mode"}, oMODE, 2'b00);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_rstn"}, oESP_RSTn, 1'b0);
    check_val({tag, "_bootn"}, oESP_BOOTn, 1'b1);
    check_val({tag, "_esprx"}, oESP_RX, 1'b1);
    check_val({tag, "_hostrx"}, oHOST_RX, 2'b11);
    check_val({tag, "_busy"}, oBUSY, 1'b1);
    check_val({tag, "_mode"}, oMODE, 2'b01);
  endtask

  initial begin
    // 1: power-on reset values and POR sequence.
    tick(3);
    @(negedge clk);
    check_reset_vals("por");
    sb.push_back('{10, 0});
    tick(1);
    iRESET = 1'b0;
    wait_seq("por_seq");
    check_idle("por_idle");

    // 3: reset-button glitch shorter than the debounce window.
    tick(1);
    iRESET_BTNn = 1'b0;
    tick(3);
    iRESET_BTNn = 1'b1;
    tick(20);
    check_val("glitch_unexp", n_unexp, 0);
    check_idle("glitch_idle");

    // 2: boot + reset buttons -> reset pulse then boot hold.
    sb.push_back('{10, 6});
    iBOOT_BTNn = 1'b0;
    iRESET_BTNn = 1'b0;
    tick(8);
    iBOOT_BTNn = 1'b1;
    iRESET_BTNn = 1'b1;
    wait_seq("boot_seq");
    check_idle("boot_idle");

    // 4: UART passthrough from host 1.
    iSEL = 1'b1;
    tick(3);
    for (int i = 0; i < 16; i++) begin
      iHOST_TX = 2'($urandom_range(0, 3));
      iESP_TX  = 1'($urandom_range(0, 1));
      uq.push_back('{cyc + 3, 1'b0, {1'b0, iHOST_TX[1]}});
      uq.push_back('{cyc + 3, 1'b1, {iESP_TX, 1'b1}});
      tick(1);
    end
    tick(5);
    check_val("uart_drained", uq.size(), 0);

    // 4: iSEL change during a sequence is ignored until idle.
    iHOST_TX = 2'b01;
    iESP_TX = 1'b0;
    sb.push_back('{10, 6});
    iBOOT_BTNn = 1'b0;
    iRESET_BTNn = 1'b0;
    wait_mode(2'b01, "sel_enter_rst");
    tick(1);
    iSEL = 1'b0;
    tick(7);
    iBOOT_BTNn = 1'b1;
    iRESET_BTNn = 1'b1;
    wait_mode(2'b10, "sel_enter_hold");
    @(negedge clk);
    check_val("hold_esp_rx_host1", oESP_RX, 1'b0);
    check_val("hold_host_rx_host1", oHOST_RX, 2'b01);
    wait_seq("sel_seq");
    tick(6);
    @(negedge clk);
    check_val("idle_esp_rx_host0", oESP_RX, 1'b1);
    check_val("idle_host_rx_host0", oHOST_RX, 2'b10);
    iHOST_TX = 2'b11;
    iESP_TX = 1'b1;

    // 5: DTR/RTS auto-reset on host 1.
    iSEL = 1'b1;
    tick(3);
`ifdef NINA_PROG_AUTORESET_EN
    sb.push_back('{10, 6});
`endif
    iHOST_RTSn = 2'b01;
    tick(4);
    iHOST_RTSn = 2'b11;
    iHOST_DTRn = 2'b01;
    tick(4);
    iHOST_DTRn = 2'b11;
    tick(30);
    wait_seq("autoreset_seq");
    check_val("autoreset_unexp", n_unexp, 0);

    // 6: iRESET during boot hold restarts the POR sequence.
    sb.push_back('{10, 6});
    iBOOT_BTNn = 1'b0;
    iRESET_BTNn = 1'b0;
    tick(8);
    iBOOT_BTNn = 1'b1;
    iRESET_BTNn = 1'b1;
    wait_mode(2'b10, "mid_enter_hold");
    tick(1);
    iRESET = 1'b1;
    sb.delete();
    sb.push_back('{10, 0});
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_reset");
    tick(1);
    iRESET = 1'b0;
    wait_seq("mid_por_seq");
    check_idle("mid_idle");

    check_val("final_unexp", n_unexp, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
